// File: rtl/fpa_pkg.sv
// Shared binary32 field widths, special encodings, operand classes and a classifier for the fpa adder.
// Pure definitions: no latency and no backpressure of its own.
package fpa_pkg;

   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int EXP_BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam logic [31:0] QNAN = 32'hFFC0_0000;

   // hidden bit + mantissa + guard/round/sticky
   localparam int SIG_W = MAN_W + 4;

   typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   function automatic fp_class_t classify(input fp32_t x);
      fp_class_t c;
      if (x.exp == '0)
         c = (x.man == '0) ? ZERO : SUB;
      else if (x.exp == EXP_MAX)
         c = (x.man == '0) ? INF : NAN;
      else
         c = NORM;
      return c;
   endfunction

endpackage

// File: rtl/fpa_lzc.sv
// Combinational leading-zero count over the 27-bit working significand; zero latency.
// No handshake: output follows input every cycle; all-zero input reports SIG_W.
module fpa_lzc
   import fpa_pkg::*;
(
   input  logic [SIG_W-1:0] i_sig,
   output logic [4:0]       o_lz
);

   // Scan upward so the most significant set bit makes the last assignment.
   always_comb begin
      o_lz = 5'(SIG_W);
      for (int i = 0; i < SIG_W; i++) begin
         if (i_sig[i]) o_lz = 5'(SIG_W - 1 - i);
      end
   end

endmodule

// File: rtl/fpa_top.sv
// IEEE-754 binary32 adder, round-to-nearest-even; result registered one cycle after operands.
// No backpressure: a new operand pair is accepted on every rising edge.
module fpa_top
   import fpa_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] number_A,
   input  logic [31:0] number_B,
   output logic [31:0] number_out
);

   fp32_t      w_a, w_b, w_l, w_s;
   fp_class_t  w_cls_a, w_cls_b;
   logic       w_a_ge_b, w_sub_op;
   logic [7:0] w_el, w_es, w_diff;
   logic [23:0] w_sig_l, w_sig_s;
   logic [26:0] w_ext_s, w_aligned;
   logic [27:0] w_sum;
   logic [4:0]  w_lz;
   logic [7:0]  w_shamt;
   logic [26:0] w_norm;
   logic [9:0]  w_exp_n, w_ef;
   logic        w_round_up;
   logic [24:0] w_rnd;
   logic [31:0] w_arith, w_res;
   logic [31:0] r_out;

   assign w_a     = number_A;
   assign w_b     = number_B;
   assign w_cls_a = classify(w_a);
   assign w_cls_b = classify(w_b);

   // Ties on magnitude keep A as the larger operand.
   assign w_a_ge_b = (w_a[30:0] >= w_b[30:0]);
   assign w_l      = w_a_ge_b ? w_a : w_b;
   assign w_s      = w_a_ge_b ? w_b : w_a;
   assign w_sub_op = w_l.sign ^ w_s.sign;

   assign w_el    = (w_l.exp == '0) ? 8'd1 : w_l.exp;
   assign w_es    = (w_s.exp == '0) ? 8'd1 : w_s.exp;
   assign w_diff  = w_el - w_es;
   assign w_sig_l = {(w_l.exp != '0), w_l.man};
   assign w_sig_s = {(w_s.exp != '0), w_s.man};
   assign w_ext_s = {w_sig_s, 3'b000};

   always_comb begin
      w_aligned = '0;
      if (w_diff >= 8'd26) begin
         w_aligned = {26'd0, |w_sig_s};
      end else begin
         w_aligned    = w_ext_s >> w_diff;
         w_aligned[0] = w_aligned[0] | (|(w_ext_s & ((27'd1 << w_diff) - 27'd1)));
      end
   end

   assign w_sum = w_sub_op ? ({1'b0, w_sig_l, 3'b000} - {1'b0, w_aligned})
                           : ({1'b0, w_sig_l, 3'b000} + {1'b0, w_aligned});

   fpa_lzc u_lzc (
      .i_sig (w_sum[26:0]),
      .o_lz  (w_lz)
   );

   // Left shift is capped so the exponent stops at 1; a missing hidden bit then means subnormal.
   always_comb begin
      w_shamt = '0;
      w_norm  = '0;
      w_exp_n = '0;
      if (w_sum[27]) begin
         w_norm  = {w_sum[27:2], w_sum[1] | w_sum[0]};
         w_exp_n = {2'b00, w_el} + 10'd1;
      end else begin
         w_shamt = ({3'b000, w_lz} < (w_el - 8'd1)) ? {3'b000, w_lz} : (w_el - 8'd1);
         w_norm  = w_sum[26:0] << w_shamt;
         w_exp_n = {2'b00, w_el - w_shamt};
      end
   end

   assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
   assign w_rnd      = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};

   always_comb begin
      w_ef = w_norm[26] ? w_exp_n : 10'd0;
      if (w_rnd[24])
         w_ef = w_ef + 10'd1;
      else if (w_rnd[23] && (w_ef == 10'd0))
         w_ef = 10'd1;
      if (w_ef >= {2'b00, EXP_MAX})
         w_arith = {w_l.sign, EXP_MAX, 23'd0};
      else
         w_arith = {w_l.sign, w_ef[7:0], w_rnd[22:0]};
   end

   always_comb begin
      w_res = w_arith;
      if (w_cls_a == NAN)
         w_res = number_A | 32'h0040_0000;
      else if (w_cls_b == NAN)
         w_res = number_B | 32'h0040_0000;
      else if ((w_cls_a == INF) && (w_cls_b == INF))
         w_res = (w_a.sign != w_b.sign) ? QNAN : number_A;
      else if (w_cls_a == INF)
         w_res = number_A;
      else if (w_cls_b == INF)
         w_res = number_B;
      else if ((w_cls_a == ZERO) && (w_cls_b == ZERO))
         w_res = {w_a.sign & w_b.sign, 31'd0};
      else if (w_cls_a == ZERO)
         w_res = number_B;
      else if (w_cls_b == ZERO)
         w_res = number_A;
      else if (w_sum == '0)
         w_res = 32'h0000_0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_out <= '0;
      else
         r_out <= w_res;
   end

   assign number_out = r_out;

endmodule

// File: tb/tb_fpa_top.sv
// Scoreboard bench for fpa_top: directed corner vectors plus random pairs against an exact-integer model.
module tb_fpa_top;

   localparam int W = 280;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a, b, out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   always #5 clk = ~clk;

   fpa_top dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .number_A   (a),
      .number_B   (b),
      .number_out (out)
   );

   // Operand value as an integer count of 2^-149 units.
   function automatic logic [W-1:0] mag(input logic [31:0] x);
      logic [W-1:0] m;
      if (x[30:23] == 8'd0) m = W'(x[22:0]);
      else                  m = W'({1'b1, x[22:0]}) << (x[30:23] - 8'd1);
      return m;
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      logic [W-1:0] mx, my, v, q, rem, half, one;
      logic s;
      int   p, sh, ex;
      if (x[30:23] == 8'hFF && x[22:0] != 0) return x | 32'h0040_0000;
      if (y[30:23] == 8'hFF && y[22:0] != 0) return y | 32'h0040_0000;
      if (x[30:23] == 8'hFF && y[30:23] == 8'hFF) return (x[31] != y[31]) ? 32'hFFC0_0000 : x;
      if (x[30:23] == 8'hFF) return x;
      if (y[30:23] == 8'hFF) return y;
      mx = mag(x);
      my = mag(y);
      if (x[31] == y[31]) begin v = mx + my; s = x[31]; end
      else if (mx >= my)  begin v = mx - my; s = x[31]; end
      else                begin v = my - mx; s = y[31]; end
      if (v == 0) return {x[31] & y[31], 31'd0};
      p = 0;
      for (int i = 0; i < W; i++) if (v[i]) p = i;
      if (p <= 23) return {s, v[30:0]};
      sh   = p - 23;
      one  = 1;
      q    = v >> sh;
      rem  = v & ((one << sh) - one);
      half = one << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + one;
      if (q[24]) begin q = q >> 1; sh++; end
      ex = sh + 1;
      if (ex >= 255) return {s, 8'hFF, 23'd0};
      return {s, 8'(ex), q[22:0]};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", nm, act, expv);
      end
   endtask

   task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv, input string nm);
      @(negedge clk);
      a = x;
      b = y;
      exp_q.push_back(expv);
      name_q.push_back(nm);
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         1: r[30:23] = 8'h00;
         2: begin r[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) r[22:0] = '0; end
         3: r[30:23] = 8'hFE - 8'($urandom_range(0, 1));
         4: r[30:0] = '0;
         5: r[30:23] = 8'($urandom_range(1, 3));
         default: ;
      endcase
      return r;
   endfunction

   // Monitor: every result is due one edge after its operands were driven.
   initial begin
      logic [31:0] e;
      string       nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, out, e);
         end
      end
   end

   localparam int ND = 11;
   logic [31:0] d_a [ND] = '{32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000, 32'h0000_0000,
                             32'h7F80_0000, 32'h7F80_0001, 32'hFF80_0000, 32'h0000_0001,
                             32'h007F_FFFF, 32'h4B80_0000, 32'h7F7F_FFFF};
   logic [31:0] d_b [ND] = '{32'h3F80_0000, 32'hBF80_0000, 32'h8000_0000, 32'h8000_0000,
                             32'hFF80_0000, 32'h3F80_0000, 32'h4120_0000, 32'h0000_0001,
                             32'h0000_0001, 32'h3F80_0000, 32'h7F7F_FFFF};
   logic [31:0] d_e [ND] = '{32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000,
                             32'hFFC0_0000, 32'h7FC0_0001, 32'hFF80_0000, 32'h0000_0002,
                             32'h0080_0000, 32'h4B80_0000, 32'h7F80_0000};

   initial begin
      logic [31:0] x, y;
      rst_n = 1'b0;
      a = 32'h3F80_0000;
      b = 32'h3F80_0000;
      @(posedge clk);
      #1;
      check("reset_out", out, 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(32'h4000_0000);
      name_q.push_back("post_reset");

      for (int i = 0; i < ND; i++)
         apply(d_a[i], d_b[i], d_e[i], $sformatf("dir%0d %08h+%08h", i, d_a[i], d_b[i]));

      for (int i = 0; i < 3000; i++) begin
         x = rand_op();
         case ($urandom_range(0, 3))
            0: y = rand_op();
            1: y = {~x[31], x[30:23] + 8'($urandom_range(0, 2)) - 8'd1, 23'($urandom)};
            2: y = x ^ 32'h8000_0000 ^ 32'($urandom_range(0, 3));
            default: y = {1'($urandom), x[30:23] - 8'($urandom_range(0, 30)), 23'($urandom)};
         endcase
         apply(x, y, ref_add(x, y), $sformatf("rand %08h+%08h", x, y));
      end

      // Reset in the middle of traffic: output clears at once, in-flight result is dropped.
      @(negedge clk);
      a = 32'h3F80_0000;
      b = 32'h3F80_0000;
      rst_n = 1'b0;
      #1;
      check("midreset_out", out, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("midreset_hold", out, 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(32'h4000_0000);
      name_q.push_back("midreset_release");
      apply(32'h4000_0000, 32'hC040_0000, 32'hBF80_0000, "after_reset 40000000+C0400000");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
